// File: rtl/register_window_file_if.sv
// Operand-read, writeback and window-control bus of the windowed register file.
// The decode/writeback stage is the master; the register file is the slave.
interface register_window_file_if #(
  parameter int NWIN  = 8,
  parameter int WIDTH = 32,
  parameter int CWPW  = 3
);
  logic [4:0]       RA, RB, WA;
  logic [WIDTH-1:0] Aout, Bout, in;
  logic             WE, Save, Restore;
  logic             WimWE, CwpWE;
  logic [NWIN-1:0]  WimIn, Wim;
  logic [CWPW-1:0]  CwpIn, Cwp;
  logic             Ovf, Unf, Ill;

  modport master (
    output RA, RB, WA, in, WE, Save, Restore, WimWE, WimIn, CwpWE, CwpIn,
    input  Aout, Bout, Cwp, Wim, Ovf, Unf, Ill
  );

  modport slave (
    input  RA, RB, WA, in, WE, Save, Restore, WimWE, WimIn, CwpWE, CwpIn,
    output Aout, Bout, Cwp, Wim, Ovf, Unf, Ill
  );
endinterface

// File: rtl/register_window_file.sv
// SPARC-style windowed register file: 8 globals + NWIN overlapping 16-register
// windows, two combinational read ports, one write port, CWP/WIM with traps.

// Maps a windowed architectural address (r8..r31) to a physical W[] index.
// Outs (r8..r15) alias the ins of the previous window, so they use cwpPrev.
module rwfAddrDecode #(
  parameter int CWPW = 3
) (
  input  logic [4:0]      addr,
  input  logic [CWPW-1:0] cwp,
  input  logic [CWPW-1:0] cwpPrev,
  output logic [CWPW+3:0] idx
);
  assign idx = {(addr[4] ? cwp : cwpPrev), (~addr[4] | addr[3]), addr[2:0]};
endmodule

module register_window_file #(
  parameter int NWIN  = 8,
  parameter int WIDTH = 32,
  parameter int CWPW  = 3
) (
  input  logic                      Clk,
  input  logic                      Rst,
  register_window_file_if.slave     rf
);
  localparam int IW    = CWPW + 4;
  localparam int NPH   = 16 * NWIN;
  localparam int NPORT = 3;  // two read decoders + one write decoder

  logic [7:0][WIDTH-1:0]   gReg;
  logic [NPH-1:0][WIDTH-1:0] wReg;
  logic [CWPW-1:0]         cwpQ;
  logic [NWIN-1:0]         wimQ;
  logic                    ovfQ, unfQ, illQ;

  function automatic logic [CWPW-1:0] wDec(input logic [CWPW-1:0] x);
    return (x == '0) ? CWPW'(NWIN - 1) : x - 1'b1;
  endfunction

  function automatic logic [CWPW-1:0] wInc(input logic [CWPW-1:0] x);
    return (x == CWPW'(NWIN - 1)) ? '0 : x + 1'b1;
  endfunction

  // Window-move / trap resolution
  logic [CWPW-1:0] cwpM1, cwpP1, cwpInMod, cwpNext, cwpNextM1;
  logic            wrOk, ovfN, unfN, illN;

  assign cwpM1     = wDec(cwpQ);
  assign cwpP1     = wInc(cwpQ);
  assign cwpNextM1 = wDec(cwpNext);
  // CWPW is ceil(log2(NWIN)), so one subtraction is enough to reduce mod NWIN
  assign cwpInMod  = ({1'b0, rf.CwpIn} >= (CWPW+1)'(NWIN)) ? rf.CwpIn - CWPW'(NWIN)
                                                            : rf.CwpIn;

  always_comb begin
    cwpNext = cwpQ;
    wrOk    = 1'b1;
    ovfN    = 1'b0;
    unfN    = 1'b0;
    illN    = 1'b0;
    if (rf.CwpWE) begin
      cwpNext = cwpInMod;
    end else if (rf.Save && rf.Restore) begin
      illN = 1'b1;
      wrOk = 1'b0;
    end else if (rf.Save) begin
      if (wimQ[cwpM1]) begin
        ovfN = 1'b1;
        wrOk = 1'b0;
      end else begin
        cwpNext = cwpM1;
      end
    end else if (rf.Restore) begin
      if (wimQ[cwpP1]) begin
        unfN = 1'b1;
        wrOk = 1'b0;
      end else begin
        cwpNext = cwpP1;
      end
    end
  end

  // Address decoders: ports 0/1 read in the current window, port 2 writes in
  // the post-move window so SAVE/RESTORE results land in the new frame.
  logic [NPORT-1:0][4:0]      decAddr;
  logic [NPORT-1:0][CWPW-1:0] decCwp, decPrev;
  logic [NPORT-1:0][IW-1:0]   decIdx;

  assign decAddr[0] = rf.RA;
  assign decAddr[1] = rf.RB;
  assign decAddr[2] = rf.WA;
  assign decCwp[0]  = cwpQ;
  assign decCwp[1]  = cwpQ;
  assign decCwp[2]  = cwpNext;
  assign decPrev[0] = cwpM1;
  assign decPrev[1] = cwpM1;
  assign decPrev[2] = cwpNextM1;

  genvar p;
  generate
    for (p = 0; p < NPORT; p++) begin : gDec
      rwfAddrDecode #(.CWPW(CWPW)) uDec (
        .addr    (decAddr[p]),
        .cwp     (decCwp[p]),
        .cwpPrev (decPrev[p]),
        .idx     (decIdx[p])
      );
    end
  endgenerate

  logic [1:0][WIDTH-1:0] rdData;

  generate
    for (p = 0; p < 2; p++) begin : gRd
      assign rdData[p] = (decAddr[p] == 5'd0)       ? '0 :
                         (decAddr[p][4:3] == 2'b00) ? gReg[decAddr[p][2:0]] :
                                                      wReg[decIdx[p]];
    end
  endgenerate

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      gReg <= '0;
      wReg <= '0;
      cwpQ <= '0;
      wimQ <= NWIN'(2);
      ovfQ <= 1'b0;
      unfQ <= 1'b0;
      illQ <= 1'b0;
    end else begin
      cwpQ <= cwpNext;
      ovfQ <= ovfN;
      unfQ <= unfN;
      illQ <= illN;
      if (rf.WimWE)
        wimQ <= rf.WimIn;
      if (rf.WE && wrOk && (rf.WA != 5'd0)) begin
        if (rf.WA[4:3] == 2'b00)
          gReg[rf.WA[2:0]] <= rf.in;
        else
          wReg[decIdx[2]] <= rf.in;
      end
    end
  end

  assign rf.Aout = rdData[0];
  assign rf.Bout = rdData[1];
  assign rf.Cwp  = cwpQ;
  assign rf.Wim  = wimQ;
  assign rf.Ovf  = ovfQ;
  assign rf.Unf  = unfQ;
  assign rf.Ill  = illQ;
endmodule

// File: tb/tb_register_window_file.sv
// Directed bench for register_window_file: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_register_window_file;
  localparam int NWIN = 8, WIDTH = 32, CWPW = 3;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  register_window_file_if #(.NWIN(NWIN), .WIDTH(WIDTH), .CWPW(CWPW)) bus ();

  register_window_file #(.NWIN(NWIN), .WIDTH(WIDTH), .CWPW(CWPW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .rf  (bus)
  );

  typedef enum int { S_A, S_B, S_CWP, S_WIM, S_OVF, S_UNF, S_ILL } sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   nChk = 0;
  int   nErr = 0;

  task automatic chk(input string name, input sel_t sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic rdA(input string name, input logic [4:0] ra, input logic [31:0] exp);
    bus.RA = ra;
    chk(name, S_A, exp);
  endtask

  task automatic rdB(input string name, input logic [4:0] rb, input logic [31:0] exp);
    bus.RB = rb;
    chk(name, S_B, exp);
  endtask

  // Advance one edge, then drop all one-shot controls
  task automatic tick();
    @(posedge Clk);
    #1;
    bus.WE = 1'b0; bus.Save = 1'b0; bus.Restore = 1'b0;
    bus.WimWE = 1'b0; bus.CwpWE = 1'b0;
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] d);
    bus.WE = 1'b1; bus.WA = wa; bus.in = d;
  endtask

  // Monitor: compares every queued expectation at the falling edge
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge Clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.sel)
          S_A:     act = bus.Aout;
          S_B:     act = bus.Bout;
          S_CWP:   act = 32'(bus.Cwp);
          S_WIM:   act = 32'(bus.Wim);
          S_OVF:   act = 32'(bus.Ovf);
          S_UNF:   act = 32'(bus.Unf);
          default: act = 32'(bus.Ill);
        endcase
        nChk++;
        if (act !== e.exp) begin
          nErr++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    bus.RA = '0; bus.RB = '0; bus.WA = '0; bus.in = '0;
    bus.WE = 1'b0; bus.Save = 1'b0; bus.Restore = 1'b0;
    bus.WimWE = 1'b0; bus.WimIn = '0; bus.CwpWE = 1'b0; bus.CwpIn = '0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    rdA("rst_a8", 5'd8, 32'h0);
    chk("rst_cwp", S_CWP, 32'd0);
    chk("rst_wim", S_WIM, 32'h02);
    chk("rst_ovf", S_OVF, 32'd0);
    chk("rst_unf", S_UNF, 32'd0);
    chk("rst_ill", S_ILL, 32'd0);
    tick();
    Rst = 1'b0;

    // Outs of window 0 alias ins of window 7
    wr(5'd8, 32'h00001111); tick();
    rdA("w0_r8", 5'd8, 32'h00001111);
    rdB("w0_r24", 5'd24, 32'h0);
    bus.Save = 1'b1; tick();
    chk("save_cwp7", S_CWP, 32'd7);
    chk("save_noovf", S_OVF, 32'd0);
    rdA("w7_r24", 5'd24, 32'h00001111);
    bus.Restore = 1'b1; tick();
    chk("rest_cwp0", S_CWP, 32'd0);

    // r0 hardwired, globals shared across windows
    wr(5'd0, 32'hFFFFFFFF); tick();
    rdA("r0_zero", 5'd0, 32'h0);
    wr(5'd3, 32'hA5A5A5A5); tick();
    bus.Save = 1'b1; tick();
    chk("g_cwp7", S_CWP, 32'd7);
    rdA("g_r3", 5'd3, 32'hA5A5A5A5);
    bus.Restore = 1'b1; tick();

    // Restore blocked by old WIM while a new WIM loads in the same cycle
    bus.Restore = 1'b1; bus.WimWE = 1'b1; bus.WimIn = 8'h01; tick();
    chk("unf_pulse", S_UNF, 32'd1);
    chk("unf_cwp", S_CWP, 32'd0);
    chk("wim_load", S_WIM, 32'h01);
    tick();
    chk("unf_clear", S_UNF, 32'd0);

    // Seven saves walk down to window 1, then window 0 is invalid
    for (int i = 1; i <= 7; i++) begin
      bus.Save = 1'b1; tick();
      chk($sformatf("walk_cwp%0d", 8 - i), S_CWP, 32'(8 - i));
    end
    bus.Save = 1'b1; wr(5'd16, 32'h0000DEAD); tick();
    chk("ovf_pulse", S_OVF, 32'd1);
    chk("ovf_cwp", S_CWP, 32'd1);
    bus.Save = 1'b1; tick();
    chk("ovf_b2b", S_OVF, 32'd1);
    tick();
    chk("ovf_clear", S_OVF, 32'd0);
    rdA("ovf_nowr", 5'd16, 32'h0);

    // Trap-handler style CWP+WIM load
    bus.CwpWE = 1'b1; bus.CwpIn = 3'd0; bus.WimWE = 1'b1; bus.WimIn = 8'h02; tick();
    chk("ld_cwp", S_CWP, 32'd0);
    chk("ld_wim", S_WIM, 32'h02);

    // Save result register lands in the new window
    bus.Save = 1'b1; wr(5'd16, 32'h0000BEEF); tick();
    chk("sw_cwp7", S_CWP, 32'd7);
    rdA("sw_w7_r16", 5'd16, 32'h0000BEEF);
    bus.Restore = 1'b1; tick();
    chk("sw_cwp0", S_CWP, 32'd0);
    rdA("sw_w0_r16", 5'd16, 32'h0);
    rdB("sw_w0_r8", 5'd8, 32'h00001111);

    // Save and Restore together are illegal
    bus.Save = 1'b1; bus.Restore = 1'b1; wr(5'd17, 32'h00001234); tick();
    chk("ill_pulse", S_ILL, 32'd1);
    chk("ill_cwp", S_CWP, 32'd0);
    rdA("ill_nowr", 5'd17, 32'h0);
    tick();
    chk("ill_clear", S_ILL, 32'd0);

    // CwpWE beats Save; write uses the loaded window
    bus.CwpWE = 1'b1; bus.CwpIn = 3'd5; bus.Save = 1'b1; wr(5'd24, 32'h0000CAFE); tick();
    chk("cwpwe_cwp5", S_CWP, 32'd5);
    chk("cwpwe_noovf", S_OVF, 32'd0);
    rdA("cwpwe_r24", 5'd24, 32'h0000CAFE);
    bus.Restore = 1'b1; tick();
    chk("rest_cwp6", S_CWP, 32'd6);
    rdA("w6_r8", 5'd8, 32'h0000CAFE);

    // Restore wraps NWIN-1 -> 0
    bus.CwpWE = 1'b1; bus.CwpIn = 3'd7; tick();
    bus.Restore = 1'b1; tick();
    chk("wrap_cwp0", S_CWP, 32'd0);

    // No bypass: same-cycle read returns old value
    wr(5'd9, 32'h00007777);
    rdA("nobyp_old", 5'd9, 32'h0);
    tick();
    rdA("nobyp_new", 5'd9, 32'h00007777);

    // Asynchronous reset between edges
    bus.WimWE = 1'b1; bus.WimIn = 8'h10; bus.Save = 1'b1; tick();
    chk("pre_cwp7", S_CWP, 32'd7);
    chk("pre_wim", S_WIM, 32'h10);
    tick();
    Rst = 1'b1;
    #1;
    rdA("arst_r9", 5'd9, 32'h0);
    rdB("arst_r3", 5'd3, 32'h0);
    chk("arst_cwp", S_CWP, 32'd0);
    chk("arst_wim", S_WIM, 32'h02);
    tick();
    Rst = 1'b0;

    repeat (2) @(posedge Clk);
    if (q.size() != 0) begin
      nChk++;
      nErr++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end
endmodule

// File: doc/register_window_file.md
# register_window_file

Parametrised SPARC-style windowed register file: 8 global registers plus NWIN overlapping windows of 16 physical registers each, with two combinational read ports and one clocked write port. It adds what the fixed 8-window register window lacks: an internal current-window pointer (CWP) advanced by SAVE/RESTORE, a window-invalid mask (WIM) with overflow and underflow trap detection, and CWP/WIM load for trap handlers. It sits in the register-file stage between decode (operand reads) and writeback.

## Interface
- NWIN, 8, number of windows; legal range 2..32
- WIDTH, 32, data width
- CWPW, 3, width of CWP; must equal ceil(log2(NWIN))
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  asynchronous, active-high reset
- RA, RB  in  5  read-port register addresses, r0..r31 architectural
- Aout, Bout  out  WIDTH  read data for RA, RB; combinational
- WA  in  5  write address
- in  in  WIDTH  write data
- WE  in  1  write enable
- Save, Restore  in  1  window move requests, sampled at the clock edge
- WimWE  in  1  load WIM from WimIn
- WimIn  in  NWIN  new WIM value
- CwpWE  in  1  load CWP from CwpIn
- CwpIn  in  CWPW  new CWP value
- Cwp  out  CWPW  current window pointer
- Wim  out  NWIN  current window-invalid mask
- Ovf, Unf, Ill  out  1  one-cycle registered trap pulses

## Operation
- Architectural map at window w: r0..r7 globals; r8..r15 outs; r16..r23 locals; r24..r31 ins.
- Physical store: 8 globals G[0..7]; windowed W[0..16*NWIN-1].
  - locals(w,k) = W[16w+k]
  - ins(w,k) = W[16w+8+k]
  - outs(w,k) = ins((w-1) mod NWIN, k)
- r0 always reads 0; writes to r0 are discarded. G[0] is never written.
- Reads decode RA/RB against the current Cwp.
- Save accepted when Save=1, Restore=0 and Wim[(Cwp-1) mod NWIN]=0: Cwp <= (Cwp-1) mod NWIN.
- Restore accepted when Restore=1, Save=0 and Wim[(Cwp+1) mod NWIN]=0: Cwp <= (Cwp+1) mod NWIN.
- Write window:
  - WE with an accepted Save/Restore in the same cycle writes using the new CWP (SAVE/RESTORE result-register semantics).
  - Otherwise the write uses the current CWP.
- Save blocked by WIM: Ovf=1 next cycle, Cwp unchanged, same-cycle write suppressed.
- Restore blocked by WIM: Unf=1 next cycle, Cwp unchanged, same-cycle write suppressed.
- Save and Restore both 1: no window move, write suppressed, Ill=1 next cycle.
- CwpWE has priority over Save/Restore: Cwp <= CwpIn, no trap flags, write (if WE) uses CwpIn. CwpIn >= NWIN is loaded as CwpIn mod NWIN.
- WimWE: Wim <= WimIn at the edge. WIM checks in the same cycle use the old Wim.
- Modular arithmetic wraps: Save at Cwp=0 gives NWIN-1; Restore at NWIN-1 gives 0.

## Timing
- Reset (asynchronous, immediate):
  - all G and W = 0
  - Cwp = 0
  - Wim = 1 << 1 (window 1 invalid)
  - Ovf = Unf = Ill = 0
- Rst asserted mid-operation aborts any pending write or window move. First update after release occurs on the first rising edge with Rst=0.
- Read latency is 0 cycles: Aout/Bout follow RA/RB/Cwp combinationally.
- A write at edge n is visible on Aout/Bout after edge n, in the same cycle RA addresses it. There is no internal bypass; read and write to the same register in one cycle return the old value.
- Cwp/Wim updates are visible after the edge; reads in the following cycle use the new window.
- Trap flags are high for exactly one cycle per blocked request; back-to-back blocked requests keep the flag high on consecutive cycles.

## Test plan
- Reset, then WE=1 WA=8 in=32'h00001111 at Cwp=0 -> next cycle RA=8 gives Aout=32'h00001111; after Save (Cwp=7), RA=24 gives 32'h00001111 (outs/ins overlap).
- WE=1 WA=0 in=32'hFFFFFFFF -> RA=0 gives Aout=0. Write 32'hA5A5A5A5 to WA=3, then Save -> RA=3 still gives 32'hA5A5A5A5 (globals shared).
- Wim=8'h02 at Cwp=0, Restore -> Unf=1 for one cycle, Cwp stays 0. Save seven times -> Cwp 7,6..1, then the eighth Save sets Ovf=1 and Cwp stays 1.
- Save with WE=1 WA=16 in=32'h0000BEEF at Cwp=0 -> Cwp=7 and W[16*7+0]=32'h0000BEEF. The local r16 of window 0 is unchanged (reads 0 after Restore).
- Save=Restore=1 with WE=1 -> Ill pulses, Cwp unchanged, no register changes. CwpWE=1 CwpIn=5 with Save=1 -> Cwp=5, Ovf=0.
- Rst asserted between edges after writes -> Aout=0 for all RA, Cwp=0, Wim=8'h02 immediately without a clock edge.
